// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: shares one single-port memory between the CPU
// (PRG space) and the PPU (CHR space). Every access takes four cycles:
// IDLE (grant) -> ISSUE (strobe) -> WAIT (read data returns) -> DONE (ack).
//
// Handshake: a requester raises req (with we/addr/wdata stable) and holds it
// until it sees a one-cycle ack. It must drop req in the cycle after ack; req
// is sampled only in IDLE, so a req still high there starts a new access.
module cart_mem_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int PPU_PRIORITY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cart_ready,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [7:0]        ppu_wdata,
    output logic              ppu_ack,
    output logic [7:0]        ppu_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_prg_sel,
    output logic              mem_chr_sel,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_start;
    logic                w_grant_ppu;
    logic                w_grant_we;

    logic                r_owner_ppu;
    logic                r_last_ppu;
    logic                r_we;
    logic [ADDR_W-1:0]   r_address;
    logic [7:0]          r_wdata;
    logic                r_prg_sel;
    logic                r_chr_sel;
    logic                r_rden;
    logic                r_wren;
    logic                r_cpu_ack;
    logic                r_ppu_ack;
    logic [7:0]          r_cpu_rdata;
    logic [7:0]          r_ppu_rdata;
    logic                r_busy;

    // Next state and grant decision; a grant only happens from IDLE.
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_grant_ppu = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cart_ready && (cpu_req || ppu_req)) begin
                    w_start = 1'b1;
                    w_next  = S_ISSUE;
                    if (cpu_req && ppu_req) begin
                        // Tie: fixed PPU priority, or hand it to whoever did not go last.
                        w_grant_ppu = (PPU_PRIORITY != 0) ? 1'b1 : ~r_last_ppu;
                    end else begin
                        w_grant_ppu = ppu_req;
                    end
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_grant_we = w_grant_ppu ? ppu_we : cpu_we;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs: strobes are set on entry to ISSUE, data/ack on entry to DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner_ppu <= 1'b0;
            r_last_ppu  <= 1'b1;
            r_we        <= 1'b0;
            r_address   <= '0;
            r_wdata     <= '0;
            r_prg_sel   <= 1'b0;
            r_chr_sel   <= 1'b0;
            r_rden      <= 1'b0;
            r_wren      <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_ppu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ppu_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_prg_sel <= 1'b0;
            r_chr_sel <= 1'b0;
            r_rden    <= 1'b0;
            r_wren    <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_ppu_ack <= 1'b0;
            r_busy    <= (w_next != S_IDLE);
            if (w_start) begin
                // we is latched so a requester that drops req mid-access cannot change it.
                r_owner_ppu <= w_grant_ppu;
                r_we        <= w_grant_we;
                r_address   <= w_grant_ppu ? ppu_addr : cpu_addr;
                r_wdata     <= w_grant_ppu ? ppu_wdata : cpu_wdata;
                r_prg_sel   <= ~w_grant_ppu;
                r_chr_sel   <= w_grant_ppu;
                r_rden      <= ~w_grant_we;
                r_wren      <= w_grant_we;
            end
            if (r_state == S_WAIT) begin
                if (!r_we) begin
                    if (r_owner_ppu) r_ppu_rdata <= mem_rdata;
                    else             r_cpu_rdata <= mem_rdata;
                end
                r_cpu_ack <= ~r_owner_ppu;
                r_ppu_ack <= r_owner_ppu;
            end
            if (r_state == S_DONE) begin
                r_last_ppu <= r_owner_ppu;
            end
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign ppu_ack     = r_ppu_ack;
    assign ppu_rdata   = r_ppu_rdata;
    assign mem_address = r_address;
    assign mem_prg_sel = r_prg_sel;
    assign mem_chr_sel = r_chr_sel;
    assign mem_rden    = r_rden;
    assign mem_wren    = r_wren;
    assign mem_wdata   = r_wdata;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule
